// File: rtl/muldiv_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: request, MTHI/MTLO
// write port and the HI/LO/busy/done status returned to the execute stage.
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;
    logic            busy;
    logic            done;

    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, wdata,
        input  HI, LO, busy, done
    );

    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, wdata,
        output HI, LO, busy, done
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one result bit per cycle,
// with MTHI/MTLO writes serviced only while idle.
//
//   state | meaning
//   IDLE  | accept start (wins over MTHI/MTLO) or service MTHI/MTLO
//   CALC  | 32 shift-add / restoring-divide iterations, cnt 0..31
//   SIGN  | sign fix-up, write HI/LO, pulse done
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic    CLK,
    input  logic    RST,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      cnt;
    logic            is_div;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic            busy_r;
    logic            done_r;

    logic            rs_neg;
    logic            rt_neg;
    logic [XLEN-1:0] rs_mag;
    logic [XLEN-1:0] rt_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_fits;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] calc_hi;
    logic [XLEN-1:0] calc_lo;
    logic [2*XLEN-1:0] product;
    logic            sign_diff;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    always_comb begin
        rs_neg    = ~bus.op[0] & bus.rs_val[XLEN-1];
        rt_neg    = ~bus.op[0] & bus.rt_val[XLEN-1];
        rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

        // Multiply: multiplier sits in acc_lo and is shifted out LSB first.
        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, a_mag}) : {1'b0, acc_hi};

        // Divide: acc_hi is the remainder, acc_lo shifts dividend out / quotient in.
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_fits  = (div_shift >= {1'b0, b_mag});
        div_diff  = div_shift[XLEN-1:0] - b_mag;

        if (is_div) begin
            calc_hi = div_fits ? div_diff : div_shift[XLEN-1:0];
            calc_lo = {acc_lo[XLEN-2:0], div_fits};
        end else begin
            calc_hi = mul_sum[XLEN:1];
            calc_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end

        sign_diff = neg_a ^ neg_b;
        product   = {acc_hi, acc_lo};
        res_hi    = acc_hi;
        res_lo    = acc_lo;
        if (!is_div) begin
            if (sign_diff) begin
                product = -product;
            end
            res_hi = product[2*XLEN-1:XLEN];
            res_lo = product[XLEN-1:0];
        end else if (b_mag == '0) begin
            // Divide by zero hands back the original dividend untouched.
            res_lo = '1;
            res_hi = neg_a ? -a_mag : a_mag;
        end else begin
            res_lo = sign_diff ? -acc_lo : acc_lo;
            res_hi = neg_a ? -acc_hi : acc_hi;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        neg_a  <= rs_neg;
                        neg_b  <= rt_neg;
                        a_mag  <= rs_mag;
                        b_mag  <= rt_mag;
                        acc_hi <= '0;
                        acc_lo <= bus.op[1] ? rs_mag : rt_mag;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end else begin
                        if (bus.mthi) hi_r <= bus.wdata;
                        if (bus.mtlo) lo_r <= bus.wdata;
                    end
                end
                CALC: begin
                    acc_hi <= calc_hi;
                    acc_lo <= calc_lo;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= SIGN;
                end
                SIGN: begin
                    hi_r   <= res_hi;
                    lo_r   <= res_lo;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: timing of busy/done, signed/unsigned results,
// divide corner cases, ignored requests, MTHI/MTLO and mid-operation reset.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_ctrl #(.XLEN(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of the first busy cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.HI, 32'h0); end
        checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.LO, 32'h0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int bad = 0;
        issue(2'b00, 32'hFFFFFFFD, 32'h00000005);
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mult_busy_window: got %0d bad cycles expected 0", bad); end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mult_done: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
        checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", bus.HI, 32'hFFFFFFFF); end
        checks++; if (bus.LO !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected %h", bus.LO, 32'hFFFFFFF1); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (33) @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b expected 1", bus.done); end
        checks++; if (bus.HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", bus.HI, 32'hFFFFFFFE); end
        checks++; if (bus.LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected %h", bus.LO, 32'h00000001); end
        issue(2'b11, 32'd64, 32'd8);
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_busy_window: got %0d bad cycles expected 0", bad); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", bus.done); end
        checks++; if (bus.LO !== 32'h00000008) begin errors++; $display("FAIL divu_lo: got %h expected %h", bus.LO, 32'h00000008); end
        checks++; if (bus.HI !== 32'h00000000) begin errors++; $display("FAIL divu_hi: got %h expected %h", bus.HI, 32'h00000000); end
        @(negedge clk);
    endtask

    task automatic test_div();
        issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
        repeat (33) @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL div_done: got %b expected 1", bus.done); end
        checks++; if (bus.LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", bus.LO, 32'hFFFFFFFD); end
        checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", bus.HI, 32'hFFFFFFFF); end
        @(negedge clk);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        repeat (33) @(negedge clk);
        checks++; if (bus.LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", bus.LO, 32'h80000000); end
        checks++; if (bus.HI !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", bus.HI, 32'h00000000); end
        @(negedge clk);
    endtask

    task automatic test_divzero();
        int bad = 0;
        issue(2'b11, 32'h00000007, 32'h00000000);
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL divzero_busy_window: got %0d bad cycles expected 0", bad); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL divzero_done: got %b expected 1", bus.done); end
        checks++; if (bus.LO !== 32'hFFFFFFFF) begin errors++; $display("FAIL divzero_lo: got %h expected %h", bus.LO, 32'hFFFFFFFF); end
        checks++; if (bus.HI !== 32'h00000007) begin errors++; $display("FAIL divzero_hi: got %h expected %h", bus.HI, 32'h00000007); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL divzero_done_once: got %b expected 0", bus.done); end
        // Signed divide by zero with a negative dividend keeps the raw dividend.
        issue(2'b10, 32'hFFFFFFF0, 32'h00000000);
        repeat (33) @(negedge clk);
        checks++; if (bus.HI !== 32'hFFFFFFF0) begin errors++; $display("FAIL sdivzero_hi: got %h expected %h", bus.HI, 32'hFFFFFFF0); end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        int bad = 0;
        issue(2'b00, 32'h00000007, 32'hFFFFFFFE);
        for (int i = 0; i < 33; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            bus.start = (i == 4);
            bus.op = 2'b11; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
            bus.mthi = (i == 9);
            bus.wdata = 32'hAAAA5555;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.mthi = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL ignore_busy_window: got %0d bad cycles expected 0", bad); end
        checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL ignore_hi: got %h expected %h", bus.HI, 32'hFFFFFFFF); end
        checks++; if (bus.LO !== 32'hFFFFFFF2) begin errors++; $display("FAIL ignore_lo: got %h expected %h", bus.LO, 32'hFFFFFFF2); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ignore_no_queue: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_mtlo_mthi();
        bus.mtlo = 1'b1; bus.wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.mtlo = 1'b0;
        checks++; if (bus.LO !== 32'h12345678) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", bus.LO, 32'h12345678); end
        checks++; if (bus.HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected %h", bus.HI, 32'hFFFFFFFF); end
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        checks++; if (bus.HI !== 32'hCAFEF00D || bus.LO !== 32'hCAFEF00D) begin errors++; $display("FAIL mthi_mtlo_both: got %h/%h expected %h/%h", bus.HI, bus.LO, 32'hCAFEF00D, 32'hCAFEF00D); end
    endtask

    task automatic test_start_priority();
        bus.mthi = 1'b1; bus.wdata = 32'hDEADBEEF;
        issue(2'b01, 32'h00010000, 32'h00010000);
        bus.mthi = 1'b0;
        checks++; if (bus.HI !== 32'hCAFEF00D) begin errors++; $display("FAIL prio_hi_dropped: got %h expected %h", bus.HI, 32'hCAFEF00D); end
        repeat (33) @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL prio_done: got %b expected 1", bus.done); end
        checks++; if (bus.HI !== 32'h00000001) begin errors++; $display("FAIL prio_hi: got %h expected %h", bus.HI, 32'h00000001); end
        checks++; if (bus.LO !== 32'h00000000) begin errors++; $display("FAIL prio_lo: got %h expected %h", bus.LO, 32'h00000000); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int bad = 0;
        bus.mtlo = 1'b1; bus.wdata = 32'h0F0F0F0F;
        @(posedge clk);
        @(negedge clk);
        bus.mtlo = 1'b0;
        issue(2'b00, 32'hFFFFFFFD, 32'h00000005);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin errors++; $display("FAIL midrst_hilo: got %h/%h expected 0/0", bus.HI, bus.LO); end
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_done: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_divzero();
        test_ignore();
        test_mtlo_mthi();
        test_start_priority();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource of the MIPS execute stage. It executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and owns the HI and LO registers. It also services MTHI/MTLO writes and exposes busy/done so the pipeline can stall MFHI/MFLO until results are valid.

Parameters:
XLEN, 32, operand and HI/LO width; only 32 is supported (the iteration counter is 5 bits).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous reset, active-high.
start  input  1  request a multiply or divide; sampled only in IDLE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
rs_val  input  32  multiplicand or dividend.
rt_val  input  32  multiplier or divisor.
mthi  input  1  write wdata to HI.
mtlo  input  1  write wdata to LO.
wdata  input  32  MTHI/MTLO data.
HI  output  32  HI register.
LO  output  32  LO register.
busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/MULT/DIV while high.
done  output  1  one-cycle pulse; HI/LO hold the new result.

Behaviour:
- Reset (edge with RST=1): state IDLE, HI=0, LO=0, busy=0, done=0. Counter and internal accumulators are cleared. Reset mid-operation abandons the operation; no partial result reaches HI/LO.
- States:
  - IDLE: start=1 latches op, |rs_val|, |rt_val| (magnitudes only for MULT/DIV) and the operand sign bits; go to CALC with counter=0.
  - CALC: 32 iterations, counter 0..31; after counter=31 go to SIGN.
  - SIGN: apply sign fix-up, write HI/LO, pulse done, go to IDLE.
- Timing: start sampled at edge N puts busy=1 from cycle N+1 to N+33 inclusive. SIGN occupies cycle N+33; HI/LO are updated at edge N+34. In cycle N+34, done=1 and busy=0. A new start may be sampled at edge N+34 (back-to-back).
- Multiply: shift-add over a 64-bit product {HI_acc, LO_acc}. MULT negates the 64-bit product in SIGN iff the operand signs differ. MULTU uses no fix-up. Result: HI = product[63:32], LO = product[31:0].
- Divide: restoring division on magnitudes, with a 33-bit partial remainder.
  - Quotient is negated iff the signs differ (DIV only).
  - Remainder takes the sign of the dividend (DIV only).
  - LO = quotient, HI = remainder.
- Divide by zero (rt_val=0, DIV or DIVU): still takes 34 cycles. LO=FFFFFFFF, HI=rs_val unchanged, no sign fix-up.
- Signed overflow, DIV 80000000/FFFFFFFF: LO=80000000, HI=00000000.
- MTHI/MTLO: in IDLE with start=0, mthi writes HI and mtlo writes LO at the next edge. Both may assert together.
- Ignored cases:
  - mthi/mtlo while busy or in SIGN are ignored.
  - start while busy is ignored; no queueing.
- Priority: start=1 together with mthi/mtlo in IDLE means start wins and the write is dropped.
- HI/LO change only at reset, on an MTHI/MTLO write, or at the SIGN-exit edge.
- done never asserts for MTHI/MTLO writes or for ignored starts.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=00000005, start at N -> busy high N+1..N+33; at N+34 done=1, HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU rs=FFFFFFFF, rt=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Issue a DIVU 64/8 back-to-back at the done cycle -> at N+68: LO=00000008, HI=0.
- DIV rs=FFFFFFF9 (-7), rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- DIVU rs=7, rt=0 -> after 34 cycles, LO=FFFFFFFF, HI=00000007, done pulses once.
- Ignore and priority: a second start at N+5 with different operands is ignored and the first result is unchanged. mthi wdata=AAAA5555 at N+10 is dropped. In IDLE, mtlo wdata=12345678 gives LO=12345678 at the next edge. start+mthi together in IDLE -> the multiply runs and HI equals the product high word.
- Reset: RST=1 at N+20 during a MULT -> next cycle busy=0, done=0, HI=LO=0. No done pulse follows.
